// File: rtl/song_reader.sv
// song_reader: walks song_rom for the selected song and issues note events over valid/ready, pacing on beat ticks
//   clk, reset_n (async active-low); play (1 run, 0 pause); song (latched leaving IDLE); beat (one-cycle tick)
//   rom_addr -> song_rom, rom_dout <- song_rom (valid one cycle after the address is sampled)
//   note_valid/note_ready handshake carrying note and note_duration; song_done held while in DONE
//   ROM word: [15] adv, [14:9] note (0 = rest), [8:3] duration in beats
//   SONG_READER_LOOP_EN: end marker / last entry wraps to entry 0 of the latched song instead of DONE
module song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    beat,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [15:0]             rom_dout,
  output logic                    note_valid,
  input  logic                    note_ready,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        note_duration,
  output logic                    song_done
);
`ifdef SONG_READER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, NEXT, DONE} state_t;
  state_t            state;
  logic [SONG_W-1:0] song_q;
  logic [IDX_W-1:0]  idx;
  logic [DUR_W-1:0]  beat_cnt;
  logic              adv_q;
  logic              w_adv;
  logic [NOTE_W-1:0] w_note;
  logic [DUR_W-1:0]  w_dur;
  logic              unused_bits;
  assign w_adv       = rom_dout[15];
  assign w_note      = rom_dout[9 +: NOTE_W];
  assign w_dur       = rom_dout[3 +: DUR_W];
  assign unused_bits = ^rom_dout[2:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      song_q        <= '0;
      idx           <= '0;
      rom_addr      <= '0;
      beat_cnt      <= '0;
      adv_q         <= 1'b0;
      note          <= '0;
      note_duration <= '0;
      note_valid    <= 1'b0;
      song_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (play) begin
          song_q   <= song;
          idx      <= '0;
          rom_addr <= {song, {IDX_W{1'b0}}};
          state    <= FETCH;
        end
        FETCH: if (play) state <= DECODE;
        DECODE: if (play) begin
          if (w_adv && w_dur == '0) begin
            // end marker: wrap to entry 0 when looping, otherwise finish
            state     <= LOOP ? FETCH : DONE;
            song_done <= !LOOP;
            if (LOOP) begin
              idx      <= '0;
              rom_addr <= {song_q, {IDX_W{1'b0}}};
            end
          end else if (w_note != '0) begin
            note          <= w_note;
            note_duration <= w_dur;
            adv_q         <= w_adv;
            note_valid    <= 1'b1;
            state         <= ISSUE;
          end else if (w_adv) begin
            beat_cnt <= w_dur;
            state    <= WAIT;
          end else begin
            state <= NEXT;
          end
        end
        // the handshake completes even while paused
        ISSUE: if (note_ready) begin
          note_valid <= 1'b0;
          beat_cnt   <= note_duration;
          state      <= adv_q ? WAIT : NEXT;
        end
        WAIT: if (play && beat) begin
          beat_cnt <= beat_cnt - 1'b1;
          if (beat_cnt == DUR_W'(1)) state <= NEXT;
        end
        NEXT: if (play) begin
          if (idx == '1) begin
            state     <= LOOP ? FETCH : DONE;
            song_done <= !LOOP;
            if (LOOP) begin
              idx      <= '0;
              rom_addr <= {song_q, {IDX_W{1'b0}}};
            end
          end else begin
            idx      <= idx + 1'b1;
            rom_addr <= {song_q, idx + 1'b1};
            state    <= FETCH;
          end
        end
        DONE: if (!play) begin
          song_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
